// File: rtl/rggen_irq_coalescer_if.sv
// Signal bundle between the status/enable register fields and the IRQ coalescer.
// The master side drives the register-derived controls; the slave side returns IRQ and event count.
interface rggen_irq_coalescer_if #(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 4,
  parameter int TIMER_WIDTH = 8
);
  logic [WIDTH-1:0]       i_status;
  logic [WIDTH-1:0]       i_enable;
  logic                   i_coalesce;
  logic [COUNT_WIDTH-1:0] i_threshold;
  logic [TIMER_WIDTH-1:0] i_timeout;
  logic                   o_irq;
  logic [COUNT_WIDTH-1:0] o_count;

  modport master (
    output i_status, i_enable, i_coalesce, i_threshold, i_timeout,
    input  o_irq, o_count
  );

  modport slave (
    input  i_status, i_enable, i_coalesce, i_threshold, i_timeout,
    output o_irq, o_count
  );
endinterface

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: counts newly raised enabled status bits and raises one registered IRQ
// on a count threshold or timeout, holding it until every pending enabled bit is cleared.
module rggen_irq_coalescer #(
  parameter int WIDTH       = 1,
  parameter int COUNT_WIDTH = 4,
  parameter int TIMER_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  rggen_irq_coalescer_if.slave bus
);

  localparam int INC_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((COUNT_WIDTH > INC_W) ? COUNT_WIDTH : INC_W) + 1;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ASSERT
  } state_e;

  state_e                 state_q;
  state_e                 next_state;
  logic [WIDTH-1:0]       active_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic                   irq_q;

  logic [WIDTH-1:0]       active;
  logic [WIDTH-1:0]       rise;
  logic [INC_W-1:0]       inc;
  logic [SUM_W-1:0]       sum;
  logic [COUNT_WIDTH-1:0] count_next;
  logic [COUNT_WIDTH-1:0] thr_eff;
  logic                   fire;

  assign active = bus.i_status & bus.i_enable;
  assign rise   = active & ~active_q;

  always_comb begin
    inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc = inc + INC_W'(rise[i]);
    end
  end

  // Count is frozen while the IRQ is up; otherwise it accumulates with a saturating add.
  always_comb begin
    sum        = SUM_W'(count_q) + SUM_W'(inc);
    count_next = count_q;
    if (state_q != ST_ASSERT) begin
      count_next = (sum > SUM_W'(COUNT_MAX)) ? COUNT_MAX : sum[COUNT_WIDTH-1:0];
    end
    thr_eff = (bus.i_threshold == '0) ? COUNT_WIDTH'(1) : bus.i_threshold;
    fire    = !bus.i_coalesce
              || (count_next >= thr_eff)
              || ((bus.i_timeout != '0) && (timer_q == bus.i_timeout - TIMER_WIDTH'(1)));
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rise != '0) begin
          next_state = fire ? ST_ASSERT : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (active == '0) begin
          next_state = ST_IDLE;
        end else if (fire) begin
          next_state = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (active == '0) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Returning to IDLE always wipes count and timer; the timer only runs while collecting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= next_state;
      active_q <= active;
      irq_q    <= (next_state == ST_ASSERT);
      if (next_state == ST_IDLE) begin
        count_q <= '0;
        timer_q <= '0;
      end else begin
        count_q <= count_next;
        if ((state_q == ST_COLLECT) && (timer_q != TIMER_MAX)) begin
          timer_q <= timer_q + TIMER_WIDTH'(1);
        end
      end
    end
  end

  assign bus.o_irq   = irq_q;
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Directed bench for rggen_irq_coalescer: a 4-bit instance for the functional scenarios and
// an 8-bit instance with a 2-bit counter for saturation.
module tb_rggen_irq_coalescer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rggen_irq_coalescer_if #(.WIDTH(4), .COUNT_WIDTH(4), .TIMER_WIDTH(8)) ifa ();
  rggen_irq_coalescer_if #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(8)) ifb ();

  rggen_irq_coalescer #(.WIDTH(4), .COUNT_WIDTH(4), .TIMER_WIDTH(8)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  rggen_irq_coalescer #(.WIDTH(8), .COUNT_WIDTH(2), .TIMER_WIDTH(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] status, input logic [3:0] enable);
    ifa.i_status = status;
    ifa.i_enable = enable;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    ifa.i_status    = '0;
    ifa.i_enable    = '0;
    ifa.i_coalesce  = 1'b1;
    ifa.i_threshold = '0;
    ifa.i_timeout   = '0;
    ifb.i_status    = '0;
    ifb.i_enable    = '0;
    ifb.i_coalesce  = 1'b1;
    ifb.i_threshold = '0;
    ifb.i_timeout   = '0;

    tick(3);
    checkOutput("reset_irq", 32'(ifa.o_irq), 32'd0);
    checkOutput("reset_count", 32'(ifa.o_count), 32'd0);
    rst = 1'b0;

    $display("[TB] bypass");
    ifa.i_coalesce = 1'b0;
    applyStimulus(4'b0000, 4'b0001);
    tick(2);
    applyStimulus(4'b0001, 4'b0001);
    #1;
    checkOutput("bypass_irq_before", 32'(ifa.o_irq), 32'd0);
    tick(1);
    checkOutput("bypass_irq_set", 32'(ifa.o_irq), 32'd1);
    checkOutput("bypass_count", 32'(ifa.o_count), 32'd1);
    tick(5);
    checkOutput("bypass_irq_hold", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0000, 4'b0001);
    tick(1);
    checkOutput("bypass_irq_clear", 32'(ifa.o_irq), 32'd0);
    checkOutput("bypass_count_clear", 32'(ifa.o_count), 32'd0);

    $display("[TB] threshold");
    ifa.i_coalesce  = 1'b1;
    ifa.i_threshold = 4'd3;
    ifa.i_timeout   = 8'd0;
    applyStimulus(4'b0000, 4'b1111);
    tick(2);
    applyStimulus(4'b0001, 4'b1111);
    tick(1);
    checkOutput("thr_count1", 32'(ifa.o_count), 32'd1);
    checkOutput("thr_irq1", 32'(ifa.o_irq), 32'd0);
    tick(3);
    checkOutput("thr_count1_hold", 32'(ifa.o_count), 32'd1);
    applyStimulus(4'b0011, 4'b1111);
    tick(1);
    checkOutput("thr_count2", 32'(ifa.o_count), 32'd2);
    checkOutput("thr_irq2", 32'(ifa.o_irq), 32'd0);
    tick(2);
    checkOutput("thr_irq2_hold", 32'(ifa.o_irq), 32'd0);
    applyStimulus(4'b0111, 4'b1111);
    tick(1);
    checkOutput("thr_count3", 32'(ifa.o_count), 32'd3);
    checkOutput("thr_irq3", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0000, 4'b1111);
    tick(1);
    checkOutput("thr_irq_clear", 32'(ifa.o_irq), 32'd0);

    $display("[TB] timeout");
    ifa.i_threshold = 4'd15;
    ifa.i_timeout   = 8'd8;
    applyStimulus(4'b0001, 4'b1111);
    tick(8);
    checkOutput("tmo_irq_early", 32'(ifa.o_irq), 32'd0);
    tick(1);
    checkOutput("tmo_irq_fire", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0000, 4'b1111);
    tick(1);
    checkOutput("tmo_irq_clear", 32'(ifa.o_irq), 32'd0);
    applyStimulus(4'b0001, 4'b1111);
    tick(4);
    checkOutput("tmo_abort_irq", 32'(ifa.o_irq), 32'd0);
    applyStimulus(4'b0000, 4'b1111);
    tick(10);
    checkOutput("tmo_abort_irq_late", 32'(ifa.o_irq), 32'd0);
    checkOutput("tmo_abort_count", 32'(ifa.o_count), 32'd0);

    $display("[TB] multi-bit and saturation");
    ifa.i_threshold = 4'd4;
    ifa.i_timeout   = 8'd0;
    applyStimulus(4'b1111, 4'b1111);
    tick(1);
    checkOutput("multi_irq", 32'(ifa.o_irq), 32'd1);
    checkOutput("multi_count", 32'(ifa.o_count), 32'd4);
    applyStimulus(4'b0000, 4'b1111);
    tick(1);
    checkOutput("multi_irq_clear", 32'(ifa.o_irq), 32'd0);
    ifb.i_threshold = 2'd3;
    ifb.i_enable    = 8'hFF;
    ifb.i_status    = 8'hFF;
    tick(1);
    checkOutput("sat_count", 32'(ifb.o_count), 32'd3);
    checkOutput("sat_irq", 32'(ifb.o_irq), 32'd1);
    ifb.i_status = 8'h00;
    tick(1);
    checkOutput("sat_irq_clear", 32'(ifb.o_irq), 32'd0);

    $display("[TB] threshold lowered at run time");
    ifa.i_threshold = 4'd15;
    applyStimulus(4'b0001, 4'b1111);
    tick(1);
    checkOutput("lower_irq_before", 32'(ifa.o_irq), 32'd0);
    ifa.i_threshold = 4'd1;
    tick(1);
    checkOutput("lower_irq_fire", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0000, 4'b1111);
    tick(1);
    checkOutput("lower_irq_clear", 32'(ifa.o_irq), 32'd0);

    $display("[TB] mask and overlap");
    ifa.i_coalesce = 1'b0;
    applyStimulus(4'b0001, 4'b1111);
    tick(1);
    checkOutput("ovl_irq_set", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0010, 4'b1111);
    tick(1);
    checkOutput("ovl_irq_nogap", 32'(ifa.o_irq), 32'd1);
    tick(1);
    checkOutput("ovl_irq_hold", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0010, 4'b0000);
    tick(1);
    checkOutput("mask_irq_clear", 32'(ifa.o_irq), 32'd0);
    applyStimulus(4'b0010, 4'b1111);
    tick(1);
    checkOutput("enable_rise_irq", 32'(ifa.o_irq), 32'd1);
    applyStimulus(4'b0000, 4'b1111);
    tick(1);
    checkOutput("enable_rise_clear", 32'(ifa.o_irq), 32'd0);

    $display("[TB] reset mid-collect");
    ifa.i_coalesce  = 1'b1;
    ifa.i_threshold = 4'd15;
    ifa.i_timeout   = 8'd0;
    applyStimulus(4'b0001, 4'b1111);
    tick(1);
    applyStimulus(4'b0011, 4'b1111);
    tick(1);
    tick(4);
    checkOutput("rst_pre_count", 32'(ifa.o_count), 32'd2);
    applyStimulus(4'b0001, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_count", 32'(ifa.o_count), 32'd0);
    checkOutput("rst_async_irq", 32'(ifa.o_irq), 32'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    checkOutput("rst_rise_count", 32'(ifa.o_count), 32'd1);
    checkOutput("rst_rise_irq", 32'(ifa.o_irq), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
